// File: rtl/response_block_pe_ot.sv
// ---------------------------------------------------------------------------
// response_block_pe_ot
//
// Per-PE request/response block. It routes one master's requests to N_SLAVE
// peripheral ports and merges their responses back into one stream. It also:
//   - tracks up to MAX_OUTSTANDING granted-but-unanswered requests,
//   - keeps all outstanding requests on a single target, so responses
//     return in order,
//   - answers unmapped slave indices from an internal error slave
//     (rdata 0, opc 1),
//   - can register the response path (REG_RESPONSE=1) or leave it
//     combinational (REG_RESPONSE=0).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   data_req_i        master request
//   data_add_i        master address; [PE_ROUTING_MSB:PE_ROUTING_LSB] is the
//                     slave index
//   data_gnt_o        grant to master
//   data_req_o        one-hot request to the slave trees
//   data_gnt_i        per-slave grant
//   data_ID_o         constant one-hot master ID (bit ID set)
//   data_r_valid_i    per-slave response valid
//   data_r_rdata_i    per-slave response data
//   data_r_opc_i      per-slave response error flag
//   data_r_valid_o    merged response valid
//   data_r_rdata_o    merged response data
//   data_r_opc_o      merged response error flag
//   outstanding_o     current outstanding count (registered)
//   err_o             sticky flag: a spurious response was seen
//
// Handshake: a request transfers in the cycle where data_req_i and
// data_gnt_o are both high. Responses carry no back-pressure. A response is
// taken in the cycle its valid is high, as long as it comes from the target
// that owns the outstanding requests.
// ---------------------------------------------------------------------------
module response_block_pe_ot #(
    parameter int N_SLAVE         = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 17,
    parameter int ID              = 1,
    parameter int PE_ROUTING_LSB  = 10,
    parameter int PE_ROUTING_MSB  = 13,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REG_RESPONSE    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_req_i,
    input  logic [ADDR_WIDTH-1:0]                data_add_i,
    output logic                                 data_gnt_o,
    output logic [N_SLAVE-1:0]                   data_req_o,
    input  logic [N_SLAVE-1:0]                   data_gnt_i,
    output logic [ID_WIDTH-1:0]                  data_ID_o,
    input  logic [N_SLAVE-1:0]                   data_r_valid_i,
    input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   data_r_rdata_i,
    input  logic [N_SLAVE-1:0]                   data_r_opc_i,
    output logic                                 data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic                                 data_r_opc_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int IW = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;
    // The target code needs one value beyond the real slaves for the error slave.
    localparam int TW = $clog2(N_SLAVE + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // Decode
    logic [IW-1:0] idx;
    logic          tgt_err;
    logic [TW-1:0] tgt;

    // State
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] cur_tgt_q, cur_tgt_d;
    logic          err_pend_q, err_pend_d;
    logic          err_q, err_d;

    // Request path
    logic          ok;
    logic          slv_gnt;
    logic          grant;

    // Response path
    logic [N_SLAVE-1:0]    exp_mask;
    logic                  slv_valid;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic                  slv_opc;
    logic                  accept;
    logic [DATA_WIDTH-1:0] src_rdata;
    logic                  src_opc;
    logic                  spurious;

    // Only the routing field of the address is used.
    logic unused_addr;
    assign unused_addr = ^data_add_i;

    assign data_ID_o = {{(ID_WIDTH-1){1'b0}}, 1'b1} << ID;

    // Decode: indices past the last slave map to the error slave.
    always_comb begin
        idx     = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
        tgt_err = (32'(idx) >= N_SLAVE);
        tgt     = tgt_err ? TW'(N_SLAVE) : TW'(idx);
    end

    // Issue is allowed when the block is idle, or when the request goes to the
    // same target and the block is not full. Both use the registered count, so
    // a slot freed by a response can only be reused in the next cycle.
    assign ok = ((cnt_q == '0) || (tgt == cur_tgt_q)) &&
                (cnt_q < CW'(MAX_OUTSTANDING));

    always_comb begin
        data_req_o = '0;
        slv_gnt    = 1'b0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if (!tgt_err && (tgt == TW'(k))) begin
                data_req_o[k] = data_req_i & ok;
                slv_gnt       = data_gnt_i[k];
            end
        end
        // The error slave grants immediately and raises no request.
        data_gnt_o = ok & (tgt_err ? data_req_i : slv_gnt);
    end

    assign grant = data_req_i & data_gnt_o;

    // Response select. Only the slave that owns the outstanding requests can
    // be accepted. Valid from any other slave is spurious and is dropped.
    always_comb begin
        exp_mask  = '0;
        slv_valid = 1'b0;
        slv_rdata = '0;
        slv_opc   = 1'b0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if ((cnt_q != '0) && (cur_tgt_q == TW'(k))) begin
                exp_mask[k] = 1'b1;
                slv_valid   = data_r_valid_i[k];
                slv_rdata   = data_r_rdata_i[k];
                slv_opc     = data_r_opc_i[k];
            end
        end
        // err_pend only exists while cur_tgt is the error slave, so it can
        // never collide with a real slave response.
        accept    = err_pend_q | slv_valid;
        src_rdata = err_pend_q ? '0   : slv_rdata;
        src_opc   = err_pend_q ? 1'b1 : slv_opc;
        spurious  = |(data_r_valid_i & ~exp_mask);
    end

    // Next state
    always_comb begin
        cnt_d      = cnt_q + CW'(grant) - CW'(accept);
        cur_tgt_d  = grant ? tgt : cur_tgt_q;
        // The pending error response is always accepted in the cycle it is
        // high, so the flag only lives for the cycle after an error grant.
        err_pend_d = grant & tgt_err;
        err_d      = err_q | spurious;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            cur_tgt_q  <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_tgt_q  <= cur_tgt_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    // Response output stage
    generate
        if (REG_RESPONSE != 0) begin : g_reg_rsp
            logic                  r_valid_q;
            logic [DATA_WIDTH-1:0] r_rdata_q;
            logic                  r_opc_q;

            // Data and opc keep their last value while valid is low.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid_q <= 1'b0;
                    r_rdata_q <= '0;
                    r_opc_q   <= 1'b0;
                end else begin
                    r_valid_q <= accept;
                    if (accept) begin
                        r_rdata_q <= src_rdata;
                        r_opc_q   <= src_opc;
                    end
                end
            end

            assign data_r_valid_o = r_valid_q;
            assign data_r_rdata_o = r_rdata_q;
            assign data_r_opc_o   = r_opc_q;
        end else begin : g_comb_rsp
            assign data_r_valid_o = accept;
            assign data_r_rdata_o = accept ? src_rdata : '0;
            assign data_r_opc_o   = accept & src_opc;
        end
    endgenerate

endmodule

// File: tb/tb_response_block_pe_ot.sv
// ---------------------------------------------------------------------------
// tb_response_block_pe_ot
//
// Bench for response_block_pe_ot with default parameters (REG_RESPONSE=1).
// Expected responses go into exp_q when a slave response is driven or an
// error-slave grant is made. A negedge monitor pops them when
// data_r_valid_o is high. Request-side behaviour is checked in-line, a
// short time after each rising edge.
// ---------------------------------------------------------------------------
module tb_response_block_pe_ot;

    localparam int N_SLAVE = 8;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int IDW     = 17;
    localparam int MAXO    = 4;
    localparam int CW      = $clog2(MAXO + 1);

    logic                        clk;
    logic                        rst;
    logic                        data_req_i;
    logic [AW-1:0]               data_add_i;
    logic                        data_gnt_o;
    logic [N_SLAVE-1:0]          data_req_o;
    logic [N_SLAVE-1:0]          data_gnt_i;
    logic [IDW-1:0]              data_ID_o;
    logic [N_SLAVE-1:0]          data_r_valid_i;
    logic [N_SLAVE-1:0][DW-1:0]  data_r_rdata_i;
    logic [N_SLAVE-1:0]          data_r_opc_i;
    logic                        data_r_valid_o;
    logic [DW-1:0]               data_r_rdata_o;
    logic                        data_r_opc_o;
    logic [CW-1:0]               outstanding_o;
    logic                        err_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Scoreboard entries are {opc, rdata}.
    logic [DW:0] exp_q[$];

    response_block_pe_ot dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_gnt_o     (data_gnt_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_ID_o      (data_ID_o),
        .data_r_valid_i (data_r_valid_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_opc_i   (data_r_opc_i),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_opc_o   (data_r_opc_o),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic req, input logic [AW-1:0] add, input logic [N_SLAVE-1:0] gnt);
        data_req_i = req;
        data_add_i = add;
        data_gnt_i = gnt;
    endtask

    task automatic set_resp(input int k, input logic [DW-1:0] d, input logic opc, input bit expect_out);
        data_r_valid_i[k] = 1'b1;
        data_r_rdata_i[k] = d;
        data_r_opc_i[k]   = opc;
        if (expect_out) exp_q.push_back({opc, d});
    endtask

    task automatic clr_resp();
        data_r_valid_i = '0;
        data_r_opc_i   = '0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && data_r_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(data_r_valid_o), 64'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(data_r_rdata_o), 64'(e[DW-1:0]));
                check("rsp_opc",   64'(data_r_opc_o),   64'(e[DW]));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        rst            = 1'b1;
        data_req_i     = 1'b0;
        data_add_i     = '0;
        data_gnt_i     = '0;
        data_r_valid_i = '0;
        data_r_rdata_i = '0;
        data_r_opc_i   = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_valid",       64'(data_r_valid_o), 64'd0);
        check("rst_rdata",       64'(data_r_rdata_o), 64'd0);
        check("rst_opc",         64'(data_r_opc_o), 64'd0);
        check("rst_err",         64'(err_o), 64'd0);
        check("id_const",        64'(data_ID_o), 64'h2);

        // Single read to slave 3
        set_req(1'b1, 32'h0000_0C00, 8'h08);
        #1;
        check("single_req_o", 64'(data_req_o), 64'h08);
        check("single_gnt",   64'(data_gnt_o), 64'd1);
        step();
        set_req(1'b0, '0, '0);
        #1;
        check("single_out1", 64'(outstanding_o), 64'd1);
        step();
        step();
        set_resp(3, 32'hDEAD_BEEF, 1'b0, 1'b1);
        #1;
        check("single_noearly", 64'(data_r_valid_o), 64'd0);
        step();
        clr_resp();
        check("single_valid", 64'(data_r_valid_o), 64'd1);
        check("single_out0",  64'(outstanding_o), 64'd0);
        step();
        check("single_pulse", 64'(data_r_valid_o), 64'd0);

        // Depth limit on slave 2
        set_req(1'b1, 32'h0000_0800, 8'h04);
        for (int i = 0; i < MAXO; i++) begin
            #1;
            check($sformatf("depth_gnt%0d", i), 64'(data_gnt_o), 64'd1);
            step();
        end
        #1;
        check("depth_full_gnt", 64'(data_gnt_o), 64'd0);
        check("depth_full_out", 64'(outstanding_o), 64'd4);
        d = $urandom;
        set_resp(2, d, 1'b0, 1'b1);
        #1;
        check("depth_same_cycle_gnt", 64'(data_gnt_o), 64'd0);
        step();
        clr_resp();
        #1;
        check("depth_next_gnt", 64'(data_gnt_o), 64'd1);
        step();
        set_req(1'b0, '0, '0);
        check("depth_refull", 64'(outstanding_o), 64'd4);
        for (int i = 0; i < MAXO; i++) begin
            d = $urandom;
            set_resp(2, d, 1'($urandom_range(0, 1)), 1'b1);
            step();
            clr_resp();
        end
        step();
        check("depth_drain", 64'(outstanding_o), 64'd0);

        // Ordering: two to slave 1, then one to slave 5
        set_req(1'b1, 32'h0000_0400, 8'h22);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("ord_gnt1_%0d", i), 64'(data_gnt_o), 64'd1);
            step();
        end
        set_req(1'b1, 32'h0000_1400, 8'h22);
        #1;
        check("ord_stall_gnt", 64'(data_gnt_o), 64'd0);
        check("ord_stall_req", 64'(data_req_o), 64'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            set_resp(1, d, 1'b0, 1'b1);
            #1;
            check($sformatf("ord_wait_gnt%0d", i), 64'(data_gnt_o), 64'd0);
            step();
            clr_resp();
        end
        #1;
        check("ord_switch_gnt", 64'(data_gnt_o), 64'd1);
        check("ord_switch_req", 64'(data_req_o), 64'h20);
        step();
        set_req(1'b0, '0, '0);
        step();
        d = $urandom;
        set_resp(5, d, 1'b1, 1'b1);
        step();
        clr_resp();
        check("ord_err_clean", 64'(err_o), 64'd0);
        step();
        check("ord_drain", 64'(outstanding_o), 64'd0);

        // Error slave (idx 9)
        set_req(1'b1, 32'h0000_2400, 8'h00);
        #1;
        check("errslv_gnt", 64'(data_gnt_o), 64'd1);
        check("errslv_req", 64'(data_req_o), 64'd0);
        exp_q.push_back({1'b1, 32'h0});
        step();
        set_req(1'b0, '0, '0);
        check("errslv_t1_valid", 64'(data_r_valid_o), 64'd0);
        check("errslv_t1_out",   64'(outstanding_o), 64'd1);
        step();
        check("errslv_t2_valid", 64'(data_r_valid_o), 64'd1);
        check("errslv_t2_opc",   64'(data_r_opc_o), 64'd1);
        check("errslv_t2_rdata", 64'(data_r_rdata_o), 64'd0);
        check("errslv_out0",     64'(outstanding_o), 64'd0);
        step();

        // Spurious response from slave 4 while idle
        set_resp(4, 32'h1234_5678, 1'b0, 1'b0);
        step();
        clr_resp();
        check("spur_err",      64'(err_o), 64'd1);
        check("spur_no_valid", 64'(data_r_valid_o), 64'd0);
        repeat (3) step();
        check("spur_sticky",   64'(err_o), 64'd1);

        // Reset clears the sticky flag
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_clears_err", 64'(err_o), 64'd0);

        // Reset mid-operation with 3 outstanding on slave 6
        set_req(1'b1, 32'h0000_1800, 8'h40);
        repeat (4) step();
        set_req(1'b0, '0, '0);
        set_resp(6, 32'hA5A5_5A5A, 1'b1, 1'b1);
        step();
        clr_resp();
        step();
        check("mid_out3", 64'(outstanding_o), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out",   64'(outstanding_o), 64'd0);
        check("mid_rst_valid", 64'(data_r_valid_o), 64'd0);
        check("mid_rst_rdata", 64'(data_r_rdata_o), 64'd0);
        check("mid_rst_opc",   64'(data_r_opc_o), 64'd0);
        check("mid_rst_gnt",   64'(data_gnt_o), 64'd0);
        check("mid_rst_req",   64'(data_req_o), 64'd0);
        step();
        rst = 1'b0;
        step();
        set_resp(6, 32'h0BAD_0BAD, 1'b0, 1'b0);
        step();
        clr_resp();
        check("late_err",      64'(err_o), 64'd1);
        check("late_no_valid", 64'(data_r_valid_o), 64'd0);
        check("late_out",      64'(outstanding_o), 64'd0);
        repeat (2) step();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
